cam_i2c_master: RTL and testbench

//  Parametrised I2C master for camera sensor register access: write and random-read.

---
 rtl/cam_i2c_master.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cam_i2c_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_i2c_master.sv
// cam_i2c_master: I2C master for camera sensor register access (write and random read).
// Register address is REG_BYTES bytes and the payload is DATA_BYTES bytes, both sent MSB byte first.
// SCL/SDA are driven open-drain through scl_oe/sda_oe, where 1 pulls the line low.
// One bit slot is four clocks (p0..p3). SCL is low in p0/p1 and released in p2/p3.
// sda_in is sampled at the end of p3.
// Optional build macro: I2C_CLK_STRETCH_EN.
//   When it is defined, the bit phase holds in p2/p3 while a slave keeps the released SCL low.
module cam_i2c_master #(
    parameter int REG_BYTES  = 2,
    parameter int DATA_BYTES = 1
) (
    input  logic                    clk400kHz,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    rw,
    input  logic [6:0]              slave_addr,
    input  logic [8*REG_BYTES-1:0]  reg_addr,
    input  logic [8*DATA_BYTES-1:0] wdata,
    output logic [8*DATA_BYTES-1:0] rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    ack_err,
    output logic                    scl_oe,
    output logic                    sda_oe,
    input  logic                    scl_in,
    input  logic                    sda_in
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_START  = 4'd1;
    localparam logic [3:0] ST_ADDR   = 4'd2;
    localparam logic [3:0] ST_REG    = 4'd3;
    localparam logic [3:0] ST_WDATA  = 4'd4;
    localparam logic [3:0] ST_RSTART = 4'd5;
    localparam logic [3:0] ST_RADDR  = 4'd6;
    localparam logic [3:0] ST_RDATA  = 4'd7;
    localparam logic [3:0] ST_STOP   = 4'd8;

    // Bit index 8 inside a byte state is the acknowledge slot.
    localparam logic [3:0] ACK_BIT   = 4'd8;
    localparam logic [1:0] REG_LAST  = 2'(REG_BYTES - 1);
    localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);

    logic [3:0]              state_r, state_s;
    logic [1:0]              phase_r, phase_s;
    logic [3:0]              bit_r, bit_s;
    logic [1:0]              byte_r, byte_s;
    logic                    rw_r;
    logic [6:0]              addr_r;
    logic [8*REG_BYTES-1:0]  reg_r;
    logic [8*DATA_BYTES-1:0] wdata_r;
    logic [8*DATA_BYTES-1:0] rx_r;
    logic                    hold_s;
    logic                    accept_s;
    logic                    slot_end_s;
    logic                    nack_s;
    logic [8*REG_BYTES-1:0]  reg_sh_s;
    logic [8*DATA_BYTES-1:0] wd_sh_s;
    logic [7:0]              tx_byte_s;
    logic [7:0]              tx_sh_s;
    logic                    tx_bit_s;
    logic                    scl_oe_s;
    logic                    sda_oe_s;

`ifdef I2C_CLK_STRETCH_EN
    // A slave stretching the clock keeps SCL low after the master has released it.
    assign hold_s = phase_r[1] & ~scl_in;
`else
    // Fixed bit timing: scl_in has no effect on the phase counter.
    logic scl_in_unused_s;
    assign scl_in_unused_s = scl_in;
    assign hold_s          = 1'b0;
`endif

    assign accept_s   = (state_r == ST_IDLE) && start;
    assign slot_end_s = (state_r != ST_IDLE) && (phase_r == 2'd3) && !hold_s;

    // Next state, phase and bit/byte counters; slot boundaries move the sequence on.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        bit_s   = bit_r;
        byte_s  = byte_r;
        nack_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            phase_s = 2'd0;
            bit_s   = 4'd0;
            byte_s  = 2'd0;
            if (start) begin
                state_s = ST_START;
            end else begin
                state_s = ST_IDLE;
            end
        end else if (hold_s) begin
            state_s = state_r;
        end else begin
            phase_s = phase_r + 2'd1;
            if (phase_r == 2'd3) begin
                case (state_r)
                    ST_START: begin
                        state_s = ST_ADDR;
                        bit_s   = 4'd0;
                        byte_s  = 2'd0;
                    end
                    ST_RSTART: begin
                        state_s = ST_RADDR;
                        bit_s   = 4'd0;
                    end
                    ST_ADDR, ST_REG, ST_WDATA, ST_RADDR: begin
                        if (bit_r != ACK_BIT) begin
                            bit_s = bit_r + 4'd1;
                        end else if (sda_in) begin
                            // A released line in the slave ACK slot means NACK: abort with STOP.
                            nack_s  = 1'b1;
                            state_s = ST_STOP;
                        end else begin
                            bit_s = 4'd0;
                            case (state_r)
                                ST_ADDR: begin
                                    state_s = ST_REG;
                                    byte_s  = 2'd0;
                                end
                                ST_REG: begin
                                    if (byte_r == REG_LAST) begin
                                        byte_s  = 2'd0;
                                        state_s = rw_r ? ST_RSTART : ST_WDATA;
                                    end else begin
                                        byte_s = byte_r + 2'd1;
                                    end
                                end
                                ST_WDATA: begin
                                    if (byte_r == DATA_LAST) begin
                                        state_s = ST_STOP;
                                    end else begin
                                        byte_s = byte_r + 2'd1;
                                    end
                                end
                                ST_RADDR: begin
                                    state_s = ST_RDATA;
                                    byte_s  = 2'd0;
                                end
                                default: state_s = ST_IDLE;
                            endcase
                        end
                    end
                    ST_RDATA: begin
                        if (bit_r != ACK_BIT) begin
                            bit_s = bit_r + 4'd1;
                        end else if (byte_r == DATA_LAST) begin
                            bit_s   = 4'd0;
                            state_s = ST_STOP;
                        end else begin
                            bit_s  = 4'd0;
                            byte_s = byte_r + 2'd1;
                        end
                    end
                    ST_STOP:  state_s = ST_IDLE;
                    default:  state_s = ST_IDLE;
                endcase
            end else begin
                state_s = state_r;
            end
        end
    end

    // Line drive for the upcoming cycle, derived from the next state so the pads are registered.
    always_comb begin
        reg_sh_s = reg_r << {byte_s, 3'b000};
        wd_sh_s  = wdata_r << {byte_s, 3'b000};
        case (state_s)
            ST_ADDR:  tx_byte_s = {addr_r, 1'b0};
            ST_RADDR: tx_byte_s = {addr_r, 1'b1};
            ST_REG:   tx_byte_s = reg_sh_s[8*REG_BYTES-1 -: 8];
            ST_WDATA: tx_byte_s = wd_sh_s[8*DATA_BYTES-1 -: 8];
            default:  tx_byte_s = 8'h00;
        endcase
        tx_sh_s  = tx_byte_s << bit_s[2:0];
        tx_bit_s = tx_sh_s[7];
        scl_oe_s = 1'b0;
        sda_oe_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                scl_oe_s = 1'b0;
                sda_oe_s = 1'b0;
            end
            ST_START: begin
                scl_oe_s = 1'b0;
                sda_oe_s = phase_s[1];
            end
            ST_RSTART: begin
                scl_oe_s = ~phase_s[1];
                sda_oe_s = phase_s[1];
            end
            ST_ADDR, ST_REG, ST_WDATA, ST_RADDR: begin
                scl_oe_s = ~phase_s[1];
                sda_oe_s = (bit_s != ACK_BIT) && !tx_bit_s;
            end
            ST_RDATA: begin
                // Master ACKs every received byte except the last, which gets NACK.
                scl_oe_s = ~phase_s[1];
                sda_oe_s = (bit_s == ACK_BIT) && (byte_s != DATA_LAST);
            end
            ST_STOP: begin
                scl_oe_s = (phase_s == 2'd0);
                sda_oe_s = (phase_s != 2'd3);
            end
            default: begin
                scl_oe_s = 1'b0;
                sda_oe_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, request latch, receive shifter and registered outputs.
    always_ff @(posedge clk400kHz) begin
        if (reset) begin
            state_r <= ST_IDLE;
            phase_r <= 2'd0;
            bit_r   <= 4'd0;
            byte_r  <= 2'd0;
            rw_r    <= 1'b0;
            addr_r  <= 7'd0;
            reg_r   <= {(8*REG_BYTES){1'b0}};
            wdata_r <= {(8*DATA_BYTES){1'b0}};
            rx_r    <= {(8*DATA_BYTES){1'b0}};
            rdata   <= {(8*DATA_BYTES){1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            bit_r   <= bit_s;
            byte_r  <= byte_s;
            scl_oe  <= scl_oe_s;
            sda_oe  <= sda_oe_s;
            busy    <= (state_s != ST_IDLE);
            done    <= slot_end_s && (state_r == ST_STOP);
            if (accept_s) begin
                rw_r    <= rw;
                addr_r  <= slave_addr;
                reg_r   <= reg_addr;
                wdata_r <= wdata;
                rx_r    <= {(8*DATA_BYTES){1'b0}};
                ack_err <= 1'b0;
            end else begin
                if (nack_s) begin
                    ack_err <= 1'b1;
                end
                if (slot_end_s && (state_r == ST_RDATA) && (bit_r != ACK_BIT)) begin
                    rx_r <= {rx_r[8*DATA_BYTES-2:0], sda_in};
                end
                // Read data is published with done, and only for a read that saw no NACK.
                if (slot_end_s && (state_r == ST_STOP) && rw_r && !ack_err) begin
                    rdata <= rx_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_i2c_master.sv
// tb_cam_i2c_master: checks three cam_i2c_master builds (REG/DATA bytes 2/1, 2/2, 1/4).
// Each transaction is checked against a bus timeline built from the protocol description.
// The timeline gives the expected SCL/SDA drive for every clock and the slave's SDA pull.
module tb_cam_i2c_master;

    localparam int NI = 3;
`ifdef I2C_CLK_STRETCH_EN
    localparam int STRETCH_EXTRA = 20;
`else
    localparam int STRETCH_EXTRA = 0;
`endif

    logic clk400kHz = 1'b0;
    logic reset;
    logic [NI-1:0]       start_v, rw_v, busy_v, done_v, ack_err_v;
    logic [NI-1:0]       scl_oe_v, sda_oe_v, scl_in_v, sda_in_v, slv_v, stretch_v;
    logic [NI-1:0][6:0]  addr_v;
    logic [NI-1:0][15:0] reg_v;
    logic [NI-1:0][31:0] wd_v, rdata_v;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic scl;
        logic sda;
        logic slv;
    } slot_t;
    slot_t       tl[$];
    int          tl_k;
    int          tl_nack;
    bit          tl_nacked;
    logic [31:0] exp_rdata [NI];

    always #5 clk400kHz = ~clk400kHz;

    function automatic int rb_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic int db_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int RB = (g == 2) ? 1 : 2;
        localparam int DB = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [8*DB-1:0] rd_w;
        cam_i2c_master #(.REG_BYTES(RB), .DATA_BYTES(DB)) u_dut (
            .clk400kHz  (clk400kHz),
            .reset      (reset),
            .start      (start_v[g]),
            .rw         (rw_v[g]),
            .slave_addr (addr_v[g]),
            .reg_addr   (reg_v[g][8*RB-1:0]),
            .wdata      (wd_v[g][8*DB-1:0]),
            .rdata      (rd_w),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .ack_err    (ack_err_v[g]),
            .scl_oe     (scl_oe_v[g]),
            .sda_oe     (sda_oe_v[g]),
            .scl_in     (scl_in_v[g]),
            .sda_in     (sda_in_v[g])
        );
        assign rdata_v[g]  = 32'(rd_w);
        assign scl_in_v[g] = ~scl_oe_v[g] & ~stretch_v[g];
        assign sda_in_v[g] = ~(sda_oe_v[g] | slv_v[g]);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic s, input logic d, input logic v, input int n);
        for (int k = 0; k < n; k++) tl.push_back('{s, d, v});
    endtask

    // Master-transmitted byte followed by the slave ACK slot (slave pulls unless NACK chosen).
    task automatic out_byte(input logic [7:0] b);
        bit nk;
        nk = (tl_k == tl_nack);
        for (int k = 7; k >= 0; k--) begin
            push(1'b1, ~b[k], 1'b0, 2);
            push(1'b0, ~b[k], 1'b0, 2);
        end
        push(1'b1, 1'b0, !nk, 2);
        push(1'b0, 1'b0, !nk, 2);
        tl_k++;
        if (nk) tl_nacked = 1'b1;
    endtask

    // Slave-transmitted byte followed by the master ACK/NACK slot.
    task automatic in_byte(input logic [7:0] b, input bit mack);
        for (int k = 7; k >= 0; k--) begin
            push(1'b1, 1'b0, ~b[k], 2);
            push(1'b0, 1'b0, ~b[k], 2);
        end
        push(1'b1, mack, 1'b0, 2);
        push(1'b0, mack, 1'b0, 2);
    endtask

    task automatic build(input int i, input bit r, input logic [6:0] a, input logic [15:0] ra,
                         input logic [31:0] w, input logic [31:0] rd, input int nack_idx);
        int rb;
        int db;
        logic [7:0] by;
        rb = rb_of(i);
        db = db_of(i);
        tl.delete();
        tl_k      = 0;
        tl_nack   = nack_idx;
        tl_nacked = 1'b0;
        push(1'b0, 1'b0, 1'b0, 2);
        push(1'b0, 1'b1, 1'b0, 2);
        out_byte({a, 1'b0});
        for (int j = 0; j < rb && !tl_nacked; j++) begin
            by = 8'(ra >> (8 * (rb - 1 - j)));
            out_byte(by);
        end
        if (!r) begin
            for (int j = 0; j < db && !tl_nacked; j++) begin
                by = 8'(w >> (8 * (db - 1 - j)));
                out_byte(by);
            end
        end else if (!tl_nacked) begin
            push(1'b1, 1'b0, 1'b0, 2);
            push(1'b0, 1'b1, 1'b0, 2);
            out_byte({a, 1'b1});
            for (int j = 0; j < db && !tl_nacked; j++) begin
                by = 8'(rd >> (8 * (db - 1 - j)));
                in_byte(by, j != db - 1);
            end
        end
        push(1'b1, 1'b1, 1'b0, 1);
        push(1'b0, 1'b1, 1'b0, 2);
        push(1'b0, 1'b0, 1'b0, 1);
        if (r && !tl_nacked)
            exp_rdata[i] = (db == 4) ? rd : (rd & ((32'd1 << (8 * db)) - 32'd1));
    endtask

    function automatic bit wave_ok(input int i, input int e);
        return (scl_oe_v[i] === tl[e].scl) && (sda_oe_v[i] === tl[e].sda) && (busy_v[i] === 1'b1);
    endfunction

    task automatic run_txn(input string nm, input int i, input bit r, input logic [6:0] a,
                           input logic [15:0] ra, input logic [31:0] w, input logic [31:0] rd,
                           input int nack_idx, input bit stretch, input bit keep_start,
                           input int exp_lat);
        int c;
        int e;
        int extra;
        int wave_err;
        bit exp_err;
        build(i, r, a, ra, w, rd, nack_idx);
        exp_err  = tl_nacked;
        extra    = stretch ? STRETCH_EXTRA : 0;
        wave_err = 0;
        @(negedge clk400kHz);
        start_v[i] = 1'b1;
        rw_v[i]    = r;
        addr_v[i]  = a;
        reg_v[i]   = ra;
        wd_v[i]    = w;
        @(negedge clk400kHz);
        if (!keep_start) start_v[i] = 1'b0;
        c = 0;
        while (!done_v[i] && c < tl.size() + extra + 64) begin
            e = c;
            if (stretch && c >= 18) e = (c < 18 + extra) ? 18 : c - extra;
            if (e < tl.size()) begin
                if (!wave_ok(i, e)) wave_err++;
                slv_v[i] = tl[e].slv;
            end else begin
                slv_v[i] = 1'b0;
            end
            stretch_v[i] = stretch && (c >= 18) && (c < 38);
            @(negedge clk400kHz);
            c++;
        end
        check({nm, ".lat"}, c, (exp_lat >= 0) ? exp_lat : tl.size() + extra);
        check({nm, ".wave"}, wave_err, 0);
        check({nm, ".done"}, done_v[i], 1'b1);
        check({nm, ".busy_end"}, busy_v[i], 1'b0);
        check({nm, ".ack_err"}, ack_err_v[i], exp_err);
        check({nm, ".rdata"}, rdata_v[i], exp_rdata[i]);
        check({nm, ".lines_idle"}, {scl_oe_v[i], sda_oe_v[i]}, 2'b00);
        slv_v[i]     = 1'b0;
        stretch_v[i] = 1'b0;
        @(negedge clk400kHz);
        check({nm, ".done_pulse"}, done_v[i], 1'b0);
        check({nm, ".busy_next"}, busy_v[i], keep_start);
    endtask

    // Global time limit so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int nd;
        int wave_err;
        reset     = 1'b1;
        start_v   = '0;
        rw_v      = '0;
        slv_v     = '0;
        stretch_v = '0;
        addr_v    = '0;
        reg_v     = '0;
        wd_v      = '0;
        for (int i = 0; i < NI; i++) exp_rdata[i] = 32'd0;
        repeat (3) @(negedge clk400kHz);
        for (int i = 0; i < NI; i++) begin
            check("rst.scl_oe", scl_oe_v[i], 1'b0);
            check("rst.sda_oe", sda_oe_v[i], 1'b0);
            check("rst.busy", busy_v[i], 1'b0);
            check("rst.done", done_v[i], 1'b0);
            check("rst.ack_err", ack_err_v[i], 1'b0);
            check("rst.rdata", rdata_v[i], 32'd0);
        end
        reset = 1'b0;
        @(negedge clk400kHz);

        run_txn("t1_write", 0, 1'b0, 7'h36, 16'h0100, 32'h01, 32'h0, -1, 1'b0, 1'b0, 152);
        run_txn("t2_read", 1, 1'b1, 7'h36, 16'h300A, 32'h0, 32'h5647, -1, 1'b0, 1'b0, 228);
        run_txn("t3_read_ok", 0, 1'b1, 7'h36, 16'h1234, 32'h0, 32'hA5, -1, 1'b0, 1'b0, 192);
        run_txn("t3_addr_nack", 0, 1'b1, 7'h36, 16'h1234, 32'h0, 32'h3C, 0, 1'b0, 1'b0, 44);
        run_txn("t3_reg_nack", 1, 1'b1, 7'h21, 16'h4455, 32'h0, 32'h1111, 2, 1'b0, 1'b0, 116);
        run_txn("t6_write4", 2, 1'b0, 7'h36, 16'h0012, 32'hDEADBEEF, 32'h0, -1, 1'b0, 1'b0, 224);
        run_txn("t5_stretch", 0, 1'b0, 7'h36, 16'h0100, 32'h5A, 32'h0, -1, 1'b1, 1'b0,
                152 + STRETCH_EXTRA);

        // Start pulse while busy is ignored; reset at cycle 50 releases the lines with no done.
        build(0, 1'b0, 7'h36, 16'h0100, 32'h01, 32'h0, -1);
        wave_err = 0;
        @(negedge clk400kHz);
        start_v[0] = 1'b1;
        rw_v[0]    = 1'b0;
        addr_v[0]  = 7'h36;
        reg_v[0]   = 16'h0100;
        wd_v[0]    = 32'h01;
        @(negedge clk400kHz);
        for (int k = 0; k < 50; k++) begin
            if (!wave_ok(0, k)) wave_err++;
            slv_v[0] = tl[k].slv;
            if (k == 10) begin
                start_v[0] = 1'b1;
                rw_v[0]    = 1'b1;
                addr_v[0]  = 7'h11;
            end else begin
                start_v[0] = 1'b0;
            end
            @(negedge clk400kHz);
        end
        check("t4.wave", wave_err, 0);
        check("t4.busy_pre", busy_v[0], 1'b1);
        reset    = 1'b1;
        slv_v[0] = 1'b0;
        @(negedge clk400kHz);
        check("t4.scl_oe", scl_oe_v[0], 1'b0);
        check("t4.sda_oe", sda_oe_v[0], 1'b0);
        check("t4.busy", busy_v[0], 1'b0);
        check("t4.done", done_v[0], 1'b0);
        for (int i = 0; i < NI; i++) exp_rdata[i] = 32'd0;
        reset = 1'b0;
        nd    = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk400kHz);
            if (done_v != '0) nd++;
        end
        check("t4.no_done", nd, 0);
        check("t4.idle", busy_v[0], 1'b0);

        // start held high: a second transaction begins right after done (slave silent -> NACK).
        run_txn("t7_held", 0, 1'b0, 7'h36, 16'hABCD, 32'h77, 32'h0, -1, 1'b0, 1'b1, 152);
        start_v[0] = 1'b0;
        c = 0;
        while (!done_v[0] && c < 200) begin
            @(negedge clk400kHz);
            c++;
        end
        check("t7.lat2", c, 44);
        check("t7.ack_err2", ack_err_v[0], 1'b1);
        @(negedge clk400kHz);

        // Randomized transactions across all three builds.
        for (int n = 0; n < 24; n++) begin
            int i;
            int nmax;
            int nk;
            bit r;
            i    = $urandom_range(0, NI - 1);
            r    = 1'($urandom_range(0, 1));
            nmax = r ? (2 + rb_of(i)) : (1 + rb_of(i) + db_of(i));
            nk   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nmax - 1) : -1;
            run_txn($sformatf("rnd%0d", n), i, r, 7'($urandom), 16'($urandom), $urandom,
                    $urandom, nk, 1'b0, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
